// File: rtl/uart_tx_queue.sv
// Buffered front end for the UART transmitter: valid/ready word queue feeding save/data pulses.
// Optional sticky overflow flag is built only when UART_TXQ_OVERFLOW_EN is defined.
module uart_tx_queue #(
    parameter int DEPTH        = 4,
    parameter int FRAME_CYCLES = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [6:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       save,
    output logic [6:0]                 data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       overflow,
    output logic [1:0]                 fsm_state_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int FW   = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              save_q, save_d;
    logic [6:0]        data_q, data_d;
    logic [6:0]        mem_q [DEPTH];

    logic              push;
    logic              pop;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready depends on count only; a full queue refuses even if a pop happens on that edge.
    assign in_ready = (count_q != CNTW'(DEPTH));
    assign push     = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (frame_q == '0) begin
                    state_d = (count_q != '0) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath logic; a pop is exactly the edge that enters LOAD
    always_comb begin
        pop      = (state_d == ST_LOAD);
        save_d   = pop;
        data_d   = pop ? mem_q[rd_ptr_q] : data_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        frame_d = frame_q;
        case (state_q)
            ST_LOAD: frame_d = FW'(FRAME_CYCLES - 2);
            ST_WAIT: begin
                if (frame_q != '0) begin
                    frame_d = frame_q - FW'(1);
                end
            end
            default: frame_d = frame_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            frame_q  <= '0;
            save_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            frame_q  <= frame_d;
            save_q   <= save_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef UART_TXQ_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign save        = save_q;
    assign data        = data_q;
    assign count       = count_q;
    assign busy        = (count_q != '0) || (state_q != ST_IDLE);
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue (DEPTH=4, FRAME_CYCLES=12), valid in both overflow builds.
module tb_uart_tx_queue;

    localparam int DEPTH = 4;
    localparam int FC    = 12;
`ifdef UART_TXQ_OVERFLOW_EN
    localparam logic OV_EXP = 1'b1;
`else
    localparam logic OV_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       save;
    logic [6:0] data;
    logic [2:0] count;
    logic       busy;
    logic       overflow;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [6:0] exp_q[$];
    int save_times[$];
    logic prev_save = 1'b0;

    uart_tx_queue #(.DEPTH(DEPTH), .FRAME_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .save(save), .data(data), .count(count),
        .busy(busy), .overflow(overflow), .fsm_state_o(fsm_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [6:0] w);
        in_valid = 1'b1;
        in_data  = w;
        exp_q.push_back(w);
        tick(1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    // Scoreboard: every save must present the next expected word, one cycle wide
    always @(negedge clk) begin
        if (save) begin
            check("save_width", 32'(prev_save), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_save", 1, 0);
            end else begin
                check("data_order", 32'(data), 32'(exp_q.pop_front()));
            end
            save_times.push_back(cyc);
        end
        prev_save = save;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int a;
        int k;
        int ticks;
        logic acc;
        logic ov_checked;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick(2);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_save", 32'(save), 0);
        check("rst_data", 32'(data), 0);
        check("rst_count", 32'(count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_state", 32'(fsm_state), 0);

        // Single push into an empty queue
        push_word(7'h55);
        in_valid = 1'b0;
        check("t1_count_n", 32'(count), 1);
        check("t1_save_n", 32'(save), 0);
        check("t1_busy_n", 32'(busy), 1);
        tick(1);
        check("t1_save_n1", 32'(save), 1);
        check("t1_data_n1", 32'(data), 32'h55);
        check("t1_count_n1", 32'(count), 0);
        tick(1);
        check("t1_save_n2", 32'(save), 0);
        check("t1_data_hold", 32'(data), 32'h55);
        tick(FC - 2);
        check("t1_busy_nf", 32'(busy), 1);
        tick(1);
        check("t1_busy_nf1", 32'(busy), 0);
        check("t1_state_idle", 32'(fsm_state), 0);
        check("t1_overflow", 32'(overflow), 0);

        // Backlog spacing
        s0 = save_times.size();
        a  = cyc + 1;
        push_word(7'h01);
        push_word(7'h02);
        push_word(7'h03);
        in_valid = 1'b0;
        wait_idle(60);
        check("t2_saves", 32'(save_times.size() - s0), 3);
        if (save_times.size() - s0 == 3) begin
            check("t2_first", 32'(save_times[s0]), 32'(a + 1));
            check("t2_gap1", 32'(save_times[s0+1] - save_times[s0]), FC);
            check("t2_gap2", 32'(save_times[s0+2] - save_times[s0+1]), FC);
        end

        // Fill to full and wrap, holding in_valid
        k = 0;
        ticks = 0;
        ov_checked = 1'b0;
        while (k < 8 && ticks < 200) begin
            in_valid = 1'b1;
            in_data  = 7'h10 + 7'(k);
            #0;
            acc = in_ready;
            if (count == 3'd4) check("t3_full_ready", 32'(in_ready), 0);
            if (acc) exp_q.push_back(in_data);
            tick(1);
            ticks++;
            if (ticks == 5) begin
                check("t3_count_full", 32'(count), 4);
                check("t3_ready_full", 32'(in_ready), 0);
            end
            if (!acc && !ov_checked) begin
                check("t3_overflow_first", 32'(overflow), 32'(OV_EXP));
                ov_checked = 1'b1;
            end
            if (acc) k++;
        end
        in_valid = 1'b0;
        check("t3_fill_cycles", 32'(ticks), 39);
        wait_idle(200);
        check("t3_drained", 32'(exp_q.size()), 0);
        check("t3_overflow_sticky", 32'(overflow), 32'(OV_EXP));

        // Push on the same edge as the pop with count=1
        push_word(7'h21);
        check("t4_count_p", 32'(count), 1);
        push_word(7'h22);
        in_valid = 1'b0;
        check("t4_count_p1", 32'(count), 1);
        check("t4_save_p1", 32'(save), 1);
        check("t4_data_p1", 32'(data), 32'h21);
        tick(FC);
        check("t4_save_p13", 32'(save), 1);
        check("t4_data_p13", 32'(data), 32'h22);
        check("t4_count_p13", 32'(count), 0);
        wait_idle(40);

        // Reset in the middle of WAIT
        s0 = save_times.size();
        a  = cyc + 1;
        push_word(7'h31);
        push_word(7'h32);
        push_word(7'h33);
        in_valid = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        exp_q.delete();
        check("t5_count", 32'(count), 0);
        check("t5_save", 32'(save), 0);
        check("t5_data", 32'(data), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_ready", 32'(in_ready), 1);
        check("t5_overflow", 32'(overflow), 0);
        rst = 1'b0;
        tick(30);
        check("t5_saves", 32'(save_times.size() - s0), 1);
        if (save_times.size() > s0) check("t5_first", 32'(save_times[s0]), 32'(a + 1));

        // Queue still works after reset
        push_word(7'h7f);
        in_valid = 1'b0;
        tick(1);
        check("t6_save", 32'(save), 1);
        check("t6_data", 32'(data), 32'h7f);
        wait_idle(40);
        check("final_exp_q", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
